video_block_source: RTL and testbench

//  Synthesizable video stream transmitter driving the colour-block detector input: emits raster frames of
//  24-bit RGB pixels with sof (first pixel of frame) and eol (last pixel of line) under valid/ready flow control.

---
 rtl/video_block_source.sv | 175 +++++++++++++++++
 tb/tb_video_block_source.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/video_block_source.sv
// rtl/video_block_source.sv - raster RGB test-pattern source with a solid rectangle on a background
//
// Purpose: emits frames of WIDTH x HEIGHT 24-bit pixels under valid/ready flow control,
// painting block_colour inside a BLOCK_W x BLOCK_H rectangle at (block_x, block_y) and
// bg_colour elsewhere. Optional idle gaps follow each line (H_GAP) and each frame (V_GAP).
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   enable             level; frames are produced back to back while high
//   block_x, block_y   rectangle top-left corner (captured at frame start)
//   block_colour       rectangle pixel value (captured at frame start)
//   bg_colour          background pixel value (captured at frame start)
//   pixel_out          pixel data, 0 when valid is low
//   valid, ready       beat handshake; a beat transfers when both are high at posedge
//   sof                beat is pixel (0,0)
//   eol                beat is the last pixel of a line
//   frame_done         one-cycle pulse after the final beat of a frame is accepted
module video_block_source #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int BLOCK_W = 32,
    parameter int BLOCK_H = 32,
    parameter int H_GAP   = 0,
    parameter int V_GAP   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [15:0] block_x,
    input  logic [15:0] block_y,
    input  logic [23:0] block_colour,
    input  logic [23:0] bg_colour,
    output logic [23:0] pixel_out,
    output logic        valid,
    input  logic        ready,
    output logic        sof,
    output logic        eol,
    output logic        frame_done
);

    localparam int XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int GMAX = (H_GAP > V_GAP) ? H_GAP : V_GAP;
    localparam int GW   = (GMAX > 1) ? $clog2(GMAX) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
    // Gap terminal counts; a zero-length gap state is never entered, so the
    // wrapped value for a zero parameter is unreachable.
    localparam logic [GW-1:0] H_LAST = GW'(H_GAP - 1);
    localparam logic [GW-1:0] V_LAST = GW'(V_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HGAP,
        S_VGAP
    } state_t;

    state_t        state, state_nxt;
    logic [XW-1:0] x, x_nxt;
    logic [YW-1:0] y, y_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic          latch;
    logic          done_nxt;

    logic [15:0]   bx_sh, by_sh;
    logic [23:0]   blk_sh, bg_sh;

    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        gap_nxt   = gap_cnt;
        latch     = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    latch     = 1'b1;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (ready) begin
                    if (x == X_LAST) begin
                        x_nxt   = '0;
                        gap_nxt = '0;
                        if (y == Y_LAST) begin
                            y_nxt     = '0;
                            done_nxt  = 1'b1;
                            state_nxt = (V_GAP > 0) ? S_VGAP : S_IDLE;
                        end else begin
                            y_nxt     = y + YW'(1);
                            state_nxt = (H_GAP > 0) ? S_HGAP : S_ACTIVE;
                        end
                    end else begin
                        x_nxt = x + XW'(1);
                    end
                end
            end
            S_HGAP: begin
                if (gap_cnt == H_LAST) begin
                    gap_nxt   = '0;
                    state_nxt = S_ACTIVE;
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            S_VGAP: begin
                if (gap_cnt == V_LAST) begin
                    gap_nxt = '0;
                    if (enable) begin
                        latch     = 1'b1;
                        state_nxt = S_ACTIVE;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + GW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            gap_cnt    <= '0;
            frame_done <= 1'b0;
            bx_sh      <= '0;
            by_sh      <= '0;
            blk_sh     <= '0;
            bg_sh      <= '0;
        end else begin
            state      <= state_nxt;
            x          <= x_nxt;
            y          <= y_nxt;
            gap_cnt    <= gap_nxt;
            frame_done <= done_nxt;
            // Configuration is captured only when a frame begins so that
            // every frame is painted with one consistent rectangle.
            if (latch) begin
                bx_sh  <= block_x;
                by_sh  <= block_y;
                blk_sh <= block_colour;
                bg_sh  <= bg_colour;
            end
        end
    end

    // Rectangle bounds in 17 bits so bx+BLOCK_W-1 cannot wrap back into the frame.
    logic [16:0] x_ext, y_ext, x_lo, x_hi, y_lo, y_hi;
    logic        in_blk;

    always_comb begin
        x_ext  = 17'(x);
        y_ext  = 17'(y);
        x_lo   = {1'b0, bx_sh};
        y_lo   = {1'b0, by_sh};
        x_hi   = x_lo + 17'(BLOCK_W - 1);
        y_hi   = y_lo + 17'(BLOCK_H - 1);
        in_blk = (x_ext >= x_lo) && (x_ext <= x_hi) && (y_ext >= y_lo) && (y_ext <= y_hi);
    end

    // Outputs are decoded from held state, so they stay stable under backpressure.
    assign valid     = (state == S_ACTIVE);
    assign pixel_out = valid ? (in_blk ? blk_sh : bg_sh) : 24'h0;
    assign sof       = valid && (x == '0) && (y == '0);
    assign eol       = valid && (x == X_LAST);

endmodule

// File: tb/tb_video_block_source.sv
// tb/tb_video_block_source.sv - directed self-checking bench for video_block_source
module tb_video_block_source;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [15:0] block_x, block_y;
    logic [23:0] block_colour, bg_colour;
    logic [23:0] pixel_out;
    logic        valid, ready, sof, eol, frame_done;

    int checks = 0;
    int errors = 0;

    localparam logic [23:0] BLK = 24'hFF0000;
    localparam logic [23:0] BG  = 24'h0000FF;

    // Beat indices (y*8+x) that carry the rectangle colour for each placement.
    localparam logic [31:0] MASK_B3_1 = (32'd1 << 11) | (32'd1 << 12) | (32'd1 << 19) | (32'd1 << 20);
    localparam logic [31:0] MASK_B5_1 = (32'd1 << 13) | (32'd1 << 14) | (32'd1 << 21) | (32'd1 << 22);
    localparam logic [31:0] MASK_B7_3 = (32'd1 << 31);
    localparam logic [31:0] MASK_NONE = 32'd0;

    video_block_source #(
        .WIDTH(8), .HEIGHT(4), .BLOCK_W(2), .BLOCK_H(2), .H_GAP(1), .V_GAP(3)
    ) dut (
        .clk(clk), .resetn(resetn), .enable(enable),
        .block_x(block_x), .block_y(block_y),
        .block_colour(block_colour), .bg_colour(bg_colour),
        .pixel_out(pixel_out), .valid(valid), .ready(ready),
        .sof(sof), .eol(eol), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drives one frame from the negedge where beat 0 is (or is about to be) presented.
    // Returns early without accepting beat stop_beat. exp_vgap < 0 means the source
    // must go idle after the frame; otherwise the count of valid=0 cycles before the
    // next sof. On return ready is 0 so any following beat 0 is held.
    task automatic run_frame(input string tag, input logic [31:0] mask, input bit rnd,
                             input int mod_beat, input logic [15:0] mod_bx,
                             input int dis_beat, input int stop_beat, input int exp_vgap);
        int          beats = 0;
        int          cyc   = 0;
        int          idle  = 0;
        bit          stalled = 1'b0;
        bit          chk_idle = 1'b0;
        bit          seen;
        logic [23:0] p_pix;
        logic        p_sof, p_eol;
        while (beats < 32 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) begin
                chk({tag, " hold_valid"}, {31'd0, valid}, 32'd1);
                chk({tag, " hold_pix"}, {8'd0, pixel_out}, {8'd0, p_pix});
                chk({tag, " hold_flags"}, {30'd0, sof, eol}, {30'd0, p_sof, p_eol});
            end
            stalled = 1'b0;
            if (valid) begin
                if (chk_idle) begin
                    chk({tag, " line_gap"}, idle, (beats % 8 == 0) ? 1 : 0);
                    chk_idle = 1'b0;
                end
                if (beats == stop_beat) begin
                    ready = 1'b0;
                    return;
                end
                if (ready) begin
                    chk({tag, " sof"}, {31'd0, sof}, {31'd0, beats == 0});
                    chk({tag, " eol"}, {31'd0, eol}, {31'd0, beats % 8 == 7});
                    chk({tag, " pix"}, {8'd0, pixel_out}, {8'd0, mask[beats] ? BLK : BG});
                    if (beats == mod_beat) block_x = mod_bx;
                    if (beats == dis_beat) enable = 1'b0;
                    beats++;
                    chk_idle = 1'b1;
                    idle = 0;
                end else begin
                    stalled = 1'b1;
                    p_pix = pixel_out;
                    p_sof = sof;
                    p_eol = eol;
                end
            end else begin
                idle++;
            end
        end
        chk({tag, " beats"}, beats, 32);
        @(negedge clk);
        ready = 1'b0;
        chk({tag, " frame_done"}, {31'd0, frame_done}, 32'd1);
        chk({tag, " done_valid"}, {31'd0, valid}, 32'd0);
        idle = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) chk({tag, " done_pulse"}, {31'd0, frame_done}, 32'd0);
            if (valid) seen = 1'b1;
            else idle++;
        end
        if (exp_vgap < 0) begin
            chk({tag, " stays_idle"}, {31'd0, seen}, 32'd0);
        end else begin
            chk({tag, " vgap_seen"}, {31'd0, seen}, 32'd1);
            chk({tag, " vgap_len"}, idle, exp_vgap);
            chk({tag, " next_sof"}, {31'd0, sof}, 32'd1);
        end
    endtask

    initial begin
        resetn = 1'b0;
        enable = 1'b0;
        ready = 1'b0;
        block_x = 16'd3;
        block_y = 16'd1;
        block_colour = BLK;
        bg_colour = BG;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset valid", {31'd0, valid}, 32'd0);
        chk("reset pix", {8'd0, pixel_out}, 32'd0);
        chk("reset flags", {29'd0, sof, eol, frame_done}, 32'd0);

        resetn = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("latency valid", {31'd0, valid}, 32'd1);
        chk("latency sof", {31'd0, sof}, 32'd1);

        run_frame("c1", MASK_B3_1, 1'b0, -1, 16'd0, -1, -1, 3);
        run_frame("c2", MASK_B3_1, 1'b1, -1, 16'd0, -1, -1, 3);

        block_x = 16'd7;
        block_y = 16'd3;
        run_frame("c3 shadow", MASK_B3_1, 1'b0, -1, 16'd0, -1, -1, 3);
        block_x = 16'd8;
        run_frame("c3 bx7", MASK_B7_3, 1'b0, -1, 16'd0, -1, -1, 3);
        block_x = 16'hFFFF;
        run_frame("c3 bx8", MASK_NONE, 1'b0, -1, 16'd0, -1, -1, 3);
        block_x = 16'd3;
        block_y = 16'd1;
        run_frame("c3 bxFFFF", MASK_NONE, 1'b0, -1, 16'd0, -1, -1, 3);

        run_frame("c4 a", MASK_B3_1, 1'b0, 10, 16'd5, 12, -1, -1);
        enable = 1'b1;
        @(negedge clk);
        chk("c4 restart sof", {31'd0, sof}, 32'd1);
        run_frame("c4 b", MASK_B5_1, 1'b0, -1, 16'd0, -1, -1, 3);

        run_frame("c5 pre", MASK_B5_1, 1'b0, -1, 16'd0, -1, 20, 3);
        resetn = 1'b0;
        @(negedge clk);
        chk("c5 valid", {31'd0, valid}, 32'd0);
        chk("c5 pix", {8'd0, pixel_out}, 32'd0);
        chk("c5 flags", {29'd0, sof, eol, frame_done}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        chk("c5 restart sof", {31'd0, sof}, 32'd1);
        run_frame("c5 post", MASK_B5_1, 1'b0, -1, 16'd0, -1, -1, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
